// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared frame geometry, coordinate types and reader FSM encoding
package frame_reader_pkg;
    localparam int FRAME_WIDTH  = 512;
    localparam int FRAME_HEIGHT = 384;
    localparam int ADDR_W       = 18;

    typedef logic [15:0]       screen_x_t;
    typedef logic [15:0]       screen_y_t;
    typedef logic [ADDR_W-1:0] pix_addr_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} reader_state_t;

    typedef struct packed {
        logic      valid;
        logic      last;
        screen_y_t y;
        screen_x_t x;
    } rd_tag_t;

    typedef struct packed {
        logic        last;
        screen_y_t   y;
        screen_x_t   x;
        logic [11:0] data;
    } pix_word_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // pointers and occupancy; flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    // storage array; contents only meaningful where count says so
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/frame_reader.sv
// frame_reader: raster-scans a rectangular window out of pixel BRAM into a valid/ready stream
module frame_reader #(
    parameter int FRAME_WIDTH  = frame_reader_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = frame_reader_pkg::FRAME_HEIGHT,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] win_x0,
    input  logic [15:0] win_y0,
    input  logic [15:0] win_w,
    input  logic [15:0] win_h,
    output logic [17:0] bram_addr,
    output logic        bram_en,
    input  logic [15:0] bram_dout,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [11:0] pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_last,
    output logic        busy,
    output logic        err
);
    import frame_reader_pkg::*;

    reader_state_t               state, next_state;
    screen_x_t                   x, x0, x_end;
    screen_y_t                   y, y_end;
    rd_tag_t                     pipe [READ_LATENCY];
    pix_word_t                   head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_empty, fifo_full_unused;
    logic                        win_ok, issue, flush, push, pop, last_addr, idle_start;
    logic [3:0]                  unused_bits;
    int                          inflight;

    assign win_ok = win_w != 16'd0 && win_h != 16'd0 &&
                    32'(win_x0) + 32'(win_w) <= 32'(FRAME_WIDTH) &&
                    32'(win_y0) + 32'(win_h) <= 32'(FRAME_HEIGHT);
    assign idle_start  = state == IDLE && start;
    assign last_addr   = x == x_end && y == y_end;
    assign flush       = abort && (state == ISSUE || state == DRAIN);
    assign push        = pipe[READ_LATENCY-1].valid && !flush;
    assign pop         = !fifo_empty && pix_ready;
    assign unused_bits = bram_dout[15:12];

    // reads issued but not yet landed in the FIFO
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) inflight += int'(pipe[i].valid);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    // next-state logic; abort only matters while a window is in progress
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && win_ok) next_state = ISSUE;
            ISSUE:   if (abort) next_state = IDLE;
                     else if (issue && last_addr) next_state = DRAIN;
            DRAIN:   if (abort) next_state = IDLE;
                     else if (fifo_empty && inflight == 0) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs; a read is issued only if the FIFO is guaranteed room for its return
    always_comb begin
        busy      = state != IDLE;
        issue     = state == ISSUE && !abort && int'(fifo_count) + inflight < FIFO_DEPTH;
        bram_en   = issue;
        bram_addr = issue ? pix_addr_t'(FRAME_WIDTH) * pix_addr_t'(y) + pix_addr_t'(x) : '0;
    end

    // window latch, raster counters and sticky error flag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            x0    <= '0;
            x_end <= '0;
            y_end <= '0;
            err   <= 1'b0;
        end else if (idle_start) begin
            err <= !win_ok;
            if (win_ok) begin
                x     <= win_x0;
                y     <= win_y0;
                x0    <= win_x0;
                x_end <= win_x0 + win_w - 16'd1;
                y_end <= win_y0 + win_h - 16'd1;
            end
        end else if (issue) begin
            x <= x == x_end ? x0 : x + 16'd1;
            y <= x == x_end ? y + 16'd1 : y;
        end

    // tags travel with each outstanding read so they meet bram_dout on its return cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {issue, last_addr, y, x};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= flush ? '0 : pipe[i-1];
        end

    sync_fifo #(
        .WIDTH($bits(pix_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({pipe[READ_LATENCY-1].last, pipe[READ_LATENCY-1].y, pipe[READ_LATENCY-1].x, bram_dout[11:0]}),
        .dout  (head),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head.data : '0;
    assign pix_x     = pix_valid ? head.x : '0;
    assign pix_y     = pix_valid ? head.y : '0;
    assign pix_last  = pix_valid && head.last;
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader windows, backpressure, abort and reset
module tb_frame_reader;
    localparam int FW = 512;
    localparam int FH = 48;
    localparam int L  = 2;
    localparam int D  = 4;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, pix_ready = 1'b0;
    logic [15:0] win_x0 = '0, win_y0 = '0, win_w = '0, win_h = '0;
    logic [17:0] bram_addr;
    logic        bram_en;
    logic [15:0] bram_dout;
    logic        pix_valid, pix_last, busy, err;
    logic [11:0] pix_data;
    logic [15:0] pix_x, pix_y;
    logic [44:0] word;

    int          tests = 0, fails = 0;
    logic [44:0] sb [$];
    logic [17:0] aq [$];
    logic [17:0] bp [L];
    int          cyc = 0, issued = 0, popped = 0, gaps = 0, lasts = 0, last_seen = 0, t0 = 0;
    logic        lat_pend = 1'b0, stab_en = 1'b0, gap_en = 1'b0, prev_stall = 1'b0;
    logic [44:0] prev_word = '0;

    frame_reader #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .READ_LATENCY(L), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    assign word      = {pix_last, pix_y, pix_x, pix_data};
    assign bram_dout = bp[L-1][15:0];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        bp[0] <= bram_addr;
        for (int i = 1; i < L; i++) bp[i] <= bp[i-1];
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            issued = 0;
            popped = 0;
            sb.delete();
            aq.delete();
            prev_stall = 1'b0;
            lat_pend = 1'b0;
        end else begin
            if (start && !busy) begin
                issued = 0;
                popped = 0;
                gaps = 0;
                lasts = 0;
                last_seen = 0;
                t0 = cyc;
                lat_pend = 1'b1;
            end
            if (lat_pend && pix_valid) begin
                check("first_lat", cyc - t0, L + 2);
                lat_pend = 1'b0;
            end
            if (bram_en) begin
                check("occupancy", issued - popped < D, 1);
                if (aq.size() > 0) check("bram_addr", bram_addr, aq.pop_front());
                else check("extra_read", bram_en, 0);
                issued++;
            end
            if (stab_en && prev_stall) check("stable", {pix_valid, word}, {1'b1, prev_word});
            if (pix_valid && pix_ready) begin
                if (sb.size() > 0) check("pixel", word, sb.pop_front());
                else check("extra_pixel", pix_valid, 0);
                popped++;
                if (pix_last) lasts++;
            end else if (gap_en && popped > 0 && sb.size() > 0 && !pix_valid) gaps++;
            if (pix_last) last_seen++;
            prev_stall = pix_valid && !pix_ready;
            prev_word = word;
        end
    end

    task automatic expect_window(int x0, int y0, int w, int h);
        logic [17:0] a;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                a = 18'(FW * (y0 + j) + x0 + i);
                aq.push_back(a);
                sb.push_back({(i == w - 1 && j == h - 1) ? 1'b1 : 1'b0, 16'(y0 + j), 16'(x0 + i), a[11:0]});
            end
    endtask

    task automatic pulse_start(int x0, int y0, int w, int h);
        win_x0 = 16'(x0);
        win_y0 = 16'(y0);
        win_w  = 16'(w);
        win_h  = 16'(h);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_window(int rnd, int poke);
        int n = 0;
        while (busy && n < 40000) begin
            pix_ready = rnd != 0 ? ($urandom_range(99) < 30) : 1'b1;
            if (poke != 0 && n == 5) begin
                win_x0 = 16'd500;
                win_w  = 16'd20;
                start  = 1'b1;
            end else start = 1'b0;
            @(posedge clk);
            #1 n++;
        end
        start = 1'b0;
        check("done", busy, 0);
        check("sb_empty", sb.size(), 0);
        check("aq_empty", aq.size(), 0);
        check("last_once", lasts, 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #15;
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_en", bram_en, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_last", pix_last, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        gap_en = 1'b1;
        expect_window(0, 0, FW, FH);
        pulse_start(0, 0, FW, FH);
        finish_window(0, 0);
        gap_en = 1'b0;
        check("frame_gaps", gaps, 0);
        check("frame_pixels", popped, FW * FH);

        expect_window(510, 1, 2, 2);
        pulse_start(510, 1, 2, 2);
        finish_window(0, 0);
        check("corner_pixels", popped, 4);

        stab_en = 1'b1;
        expect_window(100, 20, 16, 8);
        pulse_start(100, 20, 16, 8);
        finish_window(1, 1);
        stab_en = 1'b0;
        check("busy_start_err", err, 0);
        check("rand_pixels", popped, 128);

        pulse_start(500, 0, 20, 2);
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            check("reject_en", bram_en, 0);
            @(posedge clk);
            #1;
        end
        expect_window(10, 10, 3, 3);
        pulse_start(10, 10, 3, 3);
        check("err_clear", err, 0);
        finish_window(0, 0);

        pix_ready = 1'b0;
        expect_window(0, 0, 16, 8);
        pulse_start(0, 0, 16, 8);
        repeat (9) @(posedge clk);
        #1 check("pre_abort_valid", pix_valid, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_valid", pix_valid, 0);
        for (int k = 0; k < 3 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        check("abort_busy", busy, 0);
        check("abort_last", last_seen, 0);
        expect_window(7, 3, 5, 2);
        pulse_start(7, 3, 5, 2);
        finish_window(0, 0);

        pix_ready = 1'b1;
        expect_window(0, 0, 64, 4);
        pulse_start(0, 0, 64, 4);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_en", bram_en, 0);
        check("mid_rst_addr", bram_addr, 0);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_last", pix_last, 0);
        check("mid_rst_data", {pix_data, pix_x, pix_y}, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1 check("no_partial", pix_valid, 0);
        expect_window(2, 2, 8, 3);
        pulse_start(2, 2, 8, 3);
        finish_window(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 The block SHALL expose parameters: FRAME_WIDTH, default 512, pixels per line; FRAME_HEIGHT, default 384, lines per frame; READ_LATENCY, default 2, pixel BRAM port read latency in cycles; FIFO_DEPTH, default 4, output buffer entries (power of two, at least READ_LATENCY+2).
REQ-002 The block SHALL have the following ports. It uses one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a window read; ignored unless busy=0
- abort  in  1  one-cycle pulse; cancels the read in progress
- win_x0, win_y0  in  16 each  window origin (ScreenX/ScreenY)
- win_w, win_h  in  16 each  window size in pixels
- bram_addr  out  18  pixel BRAM read address
- bram_en  out  1  read strobe
- bram_dout  in  16  padded pixel word, valid READ_LATENCY cycles after bram_en
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready
- pix_data  out  12  color = bram_dout[11:0]
- pix_x, pix_y  out  16 each  frame coordinates of pix_data
- pix_last  out  1  asserted with the final pixel of the window
- busy  out  1  high from the accepted start until the FSM returns to IDLE
- err  out  1  sticky; set on a rejected window; cleared by the next accepted start

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-004 IDLE: on start, latch the window and go to ISSUE if win_w>0, win_h>0, x0+w<=FRAME_WIDTH and y0+h<=FRAME_HEIGHT; otherwise set err, stay in IDLE and keep busy=0.
REQ-005 ISSUE: raster order, x fastest; bram_addr = FRAME_WIDTH*y + x computed at 18 bits; when x reaches x0+w-1, x wraps to x0 and y increments.
REQ-006 The block SHALL assert bram_en only when (fifo occupancy + reads in flight) < FIFO_DEPTH, so that no returning read data is ever dropped.
REQ-007 A READ_LATENCY-deep shift register SHALL carry the valid bit, x, y and last of each issued read; bram_dout SHALL be pushed into the FIFO on the matching cycle.
REQ-008 After the last address is issued, the FSM SHALL go to DRAIN; DRAIN goes to DONE when the FIFO is empty and nothing is in flight; DONE goes to IDLE after one cycle.
REQ-009 The output stream follows valid/ready rules:
- pix_valid = FIFO not empty.
- pix_data, pix_x, pix_y and pix_last SHALL stay stable while pix_valid=1 and pix_ready=0.
- A transfer occurs on a cycle with valid&&ready.
REQ-010 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged. A push into a full FIFO cannot occur (guaranteed by REQ-006).
REQ-011 Zero-backpressure throughput SHALL be one pixel per cycle. First-pixel latency from start SHALL be READ_LATENCY+2 cycles.
REQ-012 abort SHALL be honoured in ISSUE or DRAIN: stop issuing reads, flush the FIFO and discard in-flight returns, deassert pix_valid on the next cycle, return to IDLE within READ_LATENCY+1 cycles, and assert no pix_last. An abort in IDLE or DONE SHALL be ignored.
REQ-013 A start received while busy=1 SHALL be ignored and SHALL NOT set err.
REQ-014 pix_last SHALL be asserted exactly once per completed window, with pixel (x0+w-1, y0+h-1).

Reset
REQ-015 While rst_n=0, the block SHALL asynchronously force: state IDLE, busy=0, err=0, bram_en=0, pix_valid=0, pix_last=0, bram_addr=0, FIFO empty, in-flight count 0.
REQ-016 Reset deassertion is synchronized externally. Reset mid-frame SHALL discard all data, with no partial output afterwards.

Structure
REQ-017 ScreenX, ScreenY, FRAME_WIDTH, FRAME_HEIGHT, the pixel address width (18) and the reader state enum SHALL live in the shared types package.
REQ-018 The output buffer SHALL be one sub-module, sync_fifo (parameterized width and depth, push/pop/full/empty/count). Address generation and the FSM stay in frame_reader.

Verification
REQ-019 Full frame with pix_ready=1 and a BRAM model returning addr[15:0]: expect 196608 pixels; first pixel (0,0) with data 0x000; pix_last on (511,383); no gaps after the first pixel.
REQ-020 Window x0=510, y0=1, w=2, h=2: expect address sequence 1022, 1023, 1534, 1535 and coordinates (510,1), (511,1), (510,2), (511,2), with pix_last on the 4th pixel.
REQ-021 Random pix_ready (~30% duty) over a 16x8 window: 128 pixels in order, none lost or duplicated, outputs stable while stalled, bram_en never asserted when occupancy+in-flight=4.
REQ-022 Start with x0=500, w=20: expect err=1, busy=0, no bram_en. A following valid start clears err.
REQ-023 abort on the 10th cycle of ISSUE with pix_ready=0: pix_valid=0 on the next cycle, busy=0 within 3 cycles, no pix_last. A new start then yields correct first pixel (x0,y0).
REQ-024 rst_n pulsed low mid-frame, asynchronously to clk: all outputs zero immediately; busy=0 after release; a following frame is correct.
